// File: rtl/jts16b_busarb_pkg.sv
// Shared definitions for the System 16B bus-arbitration logic: state encoding
// and the default ownership/hold-off limits reused by the mapper and MCU wrapper.
package jts16b_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int         JTS16B_CW      = 8;
  localparam logic [7:0] JTS16B_MAXOWN  = 8'd200;
  localparam logic [7:0] JTS16B_HOLDOFF = 8'd4;

endpackage

// File: rtl/jts16b_busarb_if.sv
// Bus signals between the 68000 / secondary master and the arbitration sequencer.
interface jts16b_busarb_if #(
  parameter int CW = 8
);
  logic          dma_req;
  logic          dma_gnt;
  logic          dma_abort;
  logic          cpu_asn;
  logic          cpu_dtackn;
  logic          cpu_bgn;
  logic          cpu_brn;
  logic          cpu_bgackn;
  logic [CW-1:0] own_cnt;

  // Arbiter side.
  modport slave (
    input  dma_req, cpu_asn, cpu_dtackn, cpu_bgn,
    output dma_gnt, dma_abort, cpu_brn, cpu_bgackn, own_cnt
  );

  // CPU / secondary-master side.
  modport master (
    output dma_req, cpu_asn, cpu_dtackn, cpu_bgn,
    input  dma_gnt, dma_abort, cpu_brn, cpu_bgackn, own_cnt
  );
endinterface

// File: rtl/jts16b_busarb_cencnt.sv
// Cen-gated saturating counter: load has priority, otherwise counts up or down
// when enabled, sticking at all-ones or zero.
module jts16b_cencnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_cen,
  input  logic          i_ld,
  input  logic [CW-1:0] i_ld_val,
  input  logic          i_en,
  input  logic          i_up,
  output logic [CW-1:0] o_cnt
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_cen) begin
      if (i_ld) begin
        r_cnt <= i_ld_val;
      end else if (i_en) begin
        if (i_up) begin
          if (r_cnt != '1) r_cnt <= r_cnt + ONE;
        end else begin
          if (r_cnt != '0) r_cnt <= r_cnt - ONE;
        end
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/jts16b_busarb.sv
// 68000 bus-arbitration sequencer: hands the CPU bus to one secondary master,
// bounds the grant length and enforces a hold-off before the next request.
module jts16b_busarb
  import jts16b_pkg::*;
#(
  parameter int            CW      = JTS16B_CW,
  parameter logic [CW-1:0] MAXOWN  = CW'(JTS16B_MAXOWN),
  parameter logic [CW-1:0] HOLDOFF = CW'(JTS16B_HOLDOFF)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cpu_cen,
  jts16b_busarb_if.slave  bus
);

  localparam logic [CW-1:0] W_LIM = MAXOWN - {{(CW-1){1'b0}}, 1'b1};

  arb_state_t    r_state, w_state_nx;
  logic          r_brn, w_brn_nx;
  logic          r_bgackn, w_bgackn_nx;
  logic          r_gnt, w_gnt_nx;
  logic          r_abort, w_abort_nx;

  logic          w_own_ld, w_own_en;
  logic          w_hold_ld, w_hold_en;
  logic [CW-1:0] w_own_cnt, w_hold_cnt;
  logic          w_bus_idle;

  // The CPU has released the bus only once BGn is low and no cycle is in flight.
  assign w_bus_idle = !bus.cpu_bgn && bus.cpu_asn && bus.cpu_dtackn;

  jts16b_cencnt #(.CW(CW)) u_own (
    .clk      (clk),
    .rstn     (rstn),
    .i_cen    (cpu_cen),
    .i_ld     (w_own_ld),
    .i_ld_val ('0),
    .i_en     (w_own_en),
    .i_up     (1'b1),
    .o_cnt    (w_own_cnt)
  );

  jts16b_cencnt #(.CW(CW)) u_hold (
    .clk      (clk),
    .rstn     (rstn),
    .i_cen    (cpu_cen),
    .i_ld     (w_hold_ld),
    .i_ld_val (HOLDOFF),
    .i_en     (w_hold_en),
    .i_up     (1'b0),
    .o_cnt    (w_hold_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_brn    <= 1'b1;
      r_bgackn <= 1'b1;
      r_gnt    <= 1'b0;
      r_abort  <= 1'b0;
    end else if (cpu_cen) begin
      r_state  <= w_state_nx;
      r_brn    <= w_brn_nx;
      r_bgackn <= w_bgackn_nx;
      r_gnt    <= w_gnt_nx;
      r_abort  <= w_abort_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_brn_nx    = r_brn;
    w_bgackn_nx = r_bgackn;
    w_gnt_nx    = r_gnt;
    w_abort_nx  = 1'b0;
    w_own_ld    = 1'b0;
    w_own_en    = 1'b0;
    w_hold_ld   = 1'b0;
    w_hold_en   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_hold_en = 1'b1;
        if (bus.dma_req && w_hold_cnt == '0) begin
          w_state_nx = REQ;
          w_brn_nx   = 1'b0;
        end
      end
      REQ: begin
        if (!bus.dma_req) begin
          w_state_nx = IDLE;
          w_brn_nx   = 1'b1;
        end else if (w_bus_idle) begin
          w_state_nx  = OWN;
          w_bgackn_nx = 1'b0;
          w_brn_nx    = 1'b1;
          w_gnt_nx    = 1'b1;
          w_own_ld    = 1'b1;
        end
      end
      OWN: begin
        w_own_en = 1'b1;
        // Voluntary release is checked first so a tie never raises abort.
        if (!bus.dma_req) begin
          w_state_nx = RELEASE;
          w_gnt_nx   = 1'b0;
        end else if (MAXOWN != '0 && w_own_cnt == W_LIM) begin
          w_state_nx = RELEASE;
          w_gnt_nx   = 1'b0;
          w_abort_nx = 1'b1;
        end
      end
      RELEASE: begin
        w_bgackn_nx = 1'b1;
        w_hold_ld   = 1'b1;
        w_state_nx  = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.cpu_brn    = r_brn;
  assign bus.cpu_bgackn = r_bgackn;
  assign bus.dma_gnt    = r_gnt;
  assign bus.dma_abort  = r_abort;
  assign bus.own_cnt    = w_own_cnt;

endmodule

// File: tb/tb_jts16b_busarb.sv
// Directed bench for jts16b_busarb with cpu_cen every 4th clock, MAXOWN=8, HOLDOFF=4.
module tb_jts16b_busarb;

  logic clk = 1'b0;
  logic rstn;
  logic cpu_cen;
  int   checks = 0;
  int   errors = 0;

  jts16b_busarb_if #(.CW(8)) bus ();

  jts16b_busarb #(.CW(8), .MAXOWN(8'd8), .HOLDOFF(8'd4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .cpu_cen (cpu_cen),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cen period: cen high on the first of four clocks; returns #1 after an edge.
  task automatic do_cen();
    cpu_cen = 1'b1;
    @(posedge clk); #1;
    cpu_cen = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic idle_cens(input int n);
    for (int i = 0; i < n; i++) do_cen();
  endtask

  initial begin
    rstn           = 1'b0;
    cpu_cen        = 1'b0;
    bus.dma_req    = 1'b0;
    bus.cpu_asn    = 1'b1;
    bus.cpu_dtackn = 1'b1;
    bus.cpu_bgn    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_brn", bus.cpu_brn, 1'b1);
    chk1("rst_bgackn", bus.cpu_bgackn, 1'b1);
    chk1("rst_gnt", bus.dma_gnt, 1'b0);
    chk1("rst_abort", bus.dma_abort, 1'b0);
    chk8("rst_own", bus.own_cnt, 8'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic grant: request at cen 0, idle bus at cen 3, withdraw at cen 10.
    bus.dma_req = 1'b1;
    do_cen();
    chk1("c0_brn", bus.cpu_brn, 1'b0);
    chk1("c0_gnt", bus.dma_gnt, 1'b0);
    idle_cens(2);
    chk1("c2_brn", bus.cpu_brn, 1'b0);
    chk1("c2_gnt", bus.dma_gnt, 1'b0);
    bus.cpu_bgn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk1("nocen_gnt", bus.dma_gnt, 1'b0);
    do_cen();
    chk1("c3_gnt", bus.dma_gnt, 1'b1);
    chk1("c3_bgackn", bus.cpu_bgackn, 1'b0);
    chk1("c3_brn", bus.cpu_brn, 1'b1);
    chk8("c3_own", bus.own_cnt, 8'd0);
    bus.cpu_bgn = 1'b1;
    idle_cens(6);
    chk8("c9_own", bus.own_cnt, 8'd6);
    chk1("c9_gnt", bus.dma_gnt, 1'b1);
    bus.dma_req = 1'b0;
    do_cen();
    chk1("c10_gnt", bus.dma_gnt, 1'b0);
    chk1("c10_bgackn", bus.cpu_bgackn, 1'b0);
    chk1("c10_abort", bus.dma_abort, 1'b0);
    do_cen();
    chk1("c11_bgackn", bus.cpu_bgackn, 1'b1);
    chk1("c11_brn", bus.cpu_brn, 1'b1);

    // Busy bus: BGn low but a cycle in progress delays the grant.
    idle_cens(4);
    bus.dma_req = 1'b1;
    do_cen();
    chk1("busy_brn", bus.cpu_brn, 1'b0);
    bus.cpu_bgn = 1'b0;
    bus.cpu_asn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_cen();
      chk1("busy_as_gnt", bus.dma_gnt, 1'b0);
    end
    bus.cpu_asn    = 1'b1;
    bus.cpu_dtackn = 1'b0;
    do_cen();
    chk1("busy_dtk_gnt", bus.dma_gnt, 1'b0);
    bus.cpu_dtackn = 1'b1;
    do_cen();
    chk1("busy_gnt", bus.dma_gnt, 1'b1);
    chk1("busy_bgackn", bus.cpu_bgackn, 1'b0);
    bus.cpu_bgn = 1'b1;

    // Limit: request held, abort on the 8th OWN cen, then hold-off of 4 cens.
    idle_cens(7);
    chk8("lim_own7", bus.own_cnt, 8'd7);
    chk1("lim_gnt7", bus.dma_gnt, 1'b1);
    chk1("lim_abort7", bus.dma_abort, 1'b0);
    do_cen();
    chk1("lim_abort", bus.dma_abort, 1'b1);
    chk1("lim_gnt", bus.dma_gnt, 1'b0);
    chk1("lim_bgackn_rel", bus.cpu_bgackn, 1'b0);
    do_cen();
    chk1("lim_abort_off", bus.dma_abort, 1'b0);
    chk1("lim_bgackn", bus.cpu_bgackn, 1'b1);
    chk1("lim_brn_rel", bus.cpu_brn, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_cen();
      chk1("hold_brn", bus.cpu_brn, 1'b1);
    end
    do_cen();
    chk1("hold_brn_end", bus.cpu_brn, 1'b0);

    // Tie: request drops on the same cen the limit is reached.
    bus.cpu_bgn = 1'b0;
    do_cen();
    chk1("tie_gnt", bus.dma_gnt, 1'b1);
    bus.cpu_bgn = 1'b1;
    idle_cens(7);
    chk8("tie_own7", bus.own_cnt, 8'd7);
    bus.dma_req = 1'b0;
    do_cen();
    chk1("tie_abort", bus.dma_abort, 1'b0);
    chk1("tie_gnt_off", bus.dma_gnt, 1'b0);
    do_cen();
    chk1("tie_abort2", bus.dma_abort, 1'b0);
    chk1("tie_bgackn", bus.cpu_bgackn, 1'b1);

    // Withdrawal: request for two cens in REQ without BGn, then dropped.
    idle_cens(4);
    bus.dma_req = 1'b1;
    do_cen();
    chk1("wd_brn0", bus.cpu_brn, 1'b0);
    do_cen();
    chk1("wd_brn1", bus.cpu_brn, 1'b0);
    bus.dma_req = 1'b0;
    do_cen();
    chk1("wd_brn", bus.cpu_brn, 1'b1);
    chk1("wd_gnt", bus.dma_gnt, 1'b0);
    chk1("wd_bgackn", bus.cpu_bgackn, 1'b1);
    do_cen();
    chk1("wd_gnt2", bus.dma_gnt, 1'b0);
    chk1("wd_brn2", bus.cpu_brn, 1'b1);

    // Asynchronous reset in the middle of a grant.
    bus.dma_req = 1'b1;
    do_cen();
    bus.cpu_bgn = 1'b0;
    do_cen();
    chk1("ar_gnt_pre", bus.dma_gnt, 1'b1);
    idle_cens(2);
    #2;
    rstn = 1'b0;
    #1;
    chk1("ar_bgackn", bus.cpu_bgackn, 1'b1);
    chk1("ar_brn", bus.cpu_brn, 1'b1);
    chk1("ar_gnt", bus.dma_gnt, 1'b0);
    chk8("ar_own", bus.own_cnt, 8'd0);
    bus.dma_req = 1'b0;
    bus.cpu_bgn = 1'b1;
    rstn = 1'b1;
    @(posedge clk); #1;
    bus.dma_req = 1'b1;
    do_cen();
    chk1("ar_idle_brn", bus.cpu_brn, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
